regfile_param: RTL and testbench

REGFILE_PARAM -- requirements
Module: regfile_param

---
 rtl/regfile_param.sv | 131 +++++++++++++
 tb/tb_regfile_param.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
// Parameterised register file with two combinational read ports, optional
// write-to-read forwarding, optional hardwired-zero register 0 and a clear
// sequencer that zeroes the whole file one entry per cycle.
//
// Write handshake: a write is taken at a rising edge when wr_en=1 and
// wr_ready=1 in that cycle. wr_ready drops only while the sequencer is
// clearing. A write presented with wr_ready=0 is dropped, not held.
module regfile_param #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 4,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_sel,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] a_sel,
    input  logic [ADDR_W-1:0] b_sel,
    output logic [DATA_W-1:0] a_data,
    output logic [DATA_W-1:0] b_data,
    output logic [DATA_W-1:0] rtop_data,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done,
    output logic [1:0]        seq_state
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } seq_t;

    seq_t              state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] regs [DEPTH];
    logic              write_fire;
    logic              write_kept;

    assign write_fire = wr_en & wr_ready;
    // With a hardwired-zero R0 the write to index 0 is accepted but never stored.
    assign write_kept = write_fire & ~((ZERO_R0 != 0) && (wr_sel == '0));

    // Sequencer state and clear-index register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Sequencer next state and status outputs; requests outside IDLE are ignored.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clr_busy = 1'b0;
        clr_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                clr_busy = 1'b1;
                if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            DONE: begin
                clr_done = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign wr_ready  = ~clr_busy;
    assign seq_state = state_q;

    // Register storage: clearing owns the file while active, otherwise writes land.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (state_q == CLEAR) begin
            regs[cnt_q] <= '0;
        end else if (write_kept) begin
            regs[wr_sel] <= wr_data;
        end
    end

    // Read port A: zero-mask beats forwarding, forwarding beats stored data.
    always_comb begin
        a_data = regs[a_sel];
        if ((ZERO_R0 != 0) && (a_sel == '0)) begin
            a_data = '0;
        end else if ((BYPASS != 0) && write_fire && (wr_sel == a_sel)) begin
            a_data = wr_data;
        end
    end

    // Read port B: same priority as port A.
    always_comb begin
        b_data = regs[b_sel];
        if ((ZERO_R0 != 0) && (b_sel == '0)) begin
            b_data = '0;
        end else if ((BYPASS != 0) && write_fire && (wr_sel == b_sel)) begin
            b_data = wr_data;
        end
    end

    // Top register is always shown as stored, never forwarded.
    assign rtop_data = regs[DEPTH-1];

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: a default instance (forwarding on, R0 writable)
// and a variant (forwarding off, R0 hardwired zero) share every input.
// A reference model of the file contents and the clear progress predicts
// every output each cycle.
module tb_regfile_param;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic       wr_en, clr_req;
    logic [3:0] wr_sel, a_sel, b_sel;
    logic [7:0] wr_data;

    logic       d_ready, d_busy, d_done;
    logic [7:0] d_a, d_b, d_rtop;
    logic [1:0] d_state;

    logic       z_ready, z_busy, z_done;
    logic [7:0] z_a, z_b, z_rtop;
    logic [1:0] z_state;

    regfile_param dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_data(wr_data), .wr_ready(d_ready), .a_sel(a_sel), .b_sel(b_sel),
        .a_data(d_a), .b_data(d_b), .rtop_data(d_rtop), .clr_req(clr_req),
        .clr_busy(d_busy), .clr_done(d_done), .seq_state(d_state)
    );

    regfile_param #(.DATA_W(8), .ADDR_W(4), .BYPASS(0), .ZERO_R0(1)) dut_alt (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_data(wr_data), .wr_ready(z_ready), .a_sel(a_sel), .b_sel(b_sel),
        .a_data(z_a), .b_data(z_b), .rtop_data(z_rtop), .clr_req(clr_req),
        .clr_busy(z_busy), .clr_done(z_done), .seq_state(z_state)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // clr_pos: -1 idle, 0..15 index being cleared this cycle, 16 done cycle.
    logic [7:0] mem_d [16];
    logic [7:0] mem_z [16];
    int clr_pos;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            mem_d[i] = 8'h00;
            mem_z[i] = 8'h00;
        end
        clr_pos = -1;
    endtask

    function automatic bit m_busy();
        return (clr_pos >= 0) && (clr_pos < 16);
    endfunction

    function automatic logic [7:0] exp_read(input bit alt, input logic [3:0] sel);
        if (alt && sel == 4'd0) return 8'h00;
        if (!alt && wr_en && !m_busy() && wr_sel == sel) return wr_data;
        return alt ? mem_z[sel] : mem_d[sel];
    endfunction

    task automatic model_edge();
        if (m_busy()) begin
            mem_d[clr_pos] = 8'h00;
            mem_z[clr_pos] = 8'h00;
            clr_pos++;
        end else begin
            if (wr_en) begin
                mem_d[wr_sel] = wr_data;
                if (wr_sel != 4'd0) mem_z[wr_sel] = wr_data;
            end
            if (clr_pos == 16) clr_pos = -1;
            else if (clr_req) clr_pos = 0;
        end
    endtask

    // ---------------- driver ----------------
    logic       obs_busy, obs_done, obs_ready;
    logic [7:0] obs_a, obs_b, obs_rtop, obs_za;

    task automatic drive(input logic we, input logic [3:0] ws, input logic [7:0] wd,
                         input logic [3:0] as, input logic [3:0] bs, input logic cr);
        wr_en = we; wr_sel = ws; wr_data = wd; a_sel = as; b_sel = bs; clr_req = cr;
    endtask

    // One cycle: compare all outputs mid-cycle, then advance the model at the edge.
    task automatic step();
        @(negedge clk);
        if (!rst_n) model_reset();
        check_eq("d_a_data", d_a, exp_read(0, a_sel));
        check_eq("d_b_data", d_b, exp_read(0, b_sel));
        check_eq("d_rtop", d_rtop, mem_d[15]);
        check_eq("d_busy", d_busy, m_busy());
        check_eq("d_done", d_done, clr_pos == 16);
        check_eq("d_ready", d_ready, !m_busy());
        check_eq("z_a_data", z_a, exp_read(1, a_sel));
        check_eq("z_b_data", z_b, exp_read(1, b_sel));
        check_eq("z_rtop", z_rtop, mem_z[15]);
        check_eq("z_busy", z_busy, m_busy());
        check_eq("z_done", z_done, clr_pos == 16);
        obs_busy = d_busy; obs_done = d_done; obs_ready = d_ready;
        obs_a = d_a; obs_b = d_b; obs_rtop = d_rtop; obs_za = z_a;
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    task automatic fill_index_plus_one();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 4'(i), 8'(i + 1), 4'(i), 4'(15 - i), 1'b0);
            step();
        end
    endtask

    // ---------------- stimulus ----------------
    int busy_cnt, done_cnt;

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 4'd0, 8'h00, 4'd0, 4'd0, 1'b0);
        model_reset();
        step();
        // Forwarding during reset on the default instance only.
        drive(1'b1, 4'd5, 8'h9C, 4'd5, 4'd6, 1'b0);
        step();
        check_eq("rst_bypass", obs_a, 8'h9C);
        check_eq("rst_no_bypass_alt", obs_za, 8'h00);
        check_eq("rst_ready", obs_ready, 1'b1);
        rst_n = 1'b1;

        // Same-cycle forwarding vs. stored value.
        drive(1'b1, 4'd7, 8'h5A, 4'd7, 4'd0, 1'b0);
        step();
        check_eq("r037_bypass", obs_a, 8'h5A);
        check_eq("r037_nobypass", obs_za, 8'h00);

        // Basic write then read, including the top register.
        drive(1'b1, 4'd3, 8'hA5, 4'd0, 4'd0, 1'b0);
        step();
        drive(1'b0, 4'd0, 8'h00, 4'd3, 4'd0, 1'b0);
        step();
        check_eq("r036_a3", obs_a, 8'hA5);
        drive(1'b1, 4'd15, 8'h3C, 4'd0, 4'd0, 1'b0);
        step();
        drive(1'b0, 4'd0, 8'h00, 4'd0, 4'd15, 1'b0);
        step();
        check_eq("r036_b15", obs_b, 8'h3C);
        check_eq("r036_rtop", obs_rtop, 8'h3C);

        // Fill, read back through the expected queue, then full clear.
        fill_index_plus_one();
        for (int i = 0; i < 16; i++) exp_q.push_back(8'(i + 1));
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 4'd0, 8'h00, 4'(i), 4'd0, 1'b0);
            step();
            check_eq("fill_rd", obs_a, exp_q.pop_front());
        end
        drive(1'b0, 4'd0, 8'h00, 4'd0, 4'd0, 1'b1);
        step();
        drive(1'b0, 4'd0, 8'h00, 4'd0, 4'd0, 1'b0);
        busy_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            busy_cnt += int'(obs_busy);
            done_cnt += int'(obs_done);
        end
        check_eq("r038_busy_len", busy_cnt, 16);
        check_eq("r038_done_len", done_cnt, 1);
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 4'd0, 8'h00, 4'(i), 4'(15 - i), 1'b0);
            step();
            check_eq("r038_zero", obs_a, 8'h00);
        end

        // Write and re-request during clear are both dropped.
        fill_index_plus_one();
        drive(1'b0, 4'd0, 8'h00, 4'd2, 4'd0, 1'b1);
        step();
        busy_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 24; i++) begin
            if (i >= 8 && i < 11) drive(1'b1, 4'd2, 8'h77, 4'd2, 4'd2, 1'b1);
            else drive(1'b0, 4'd0, 8'h00, 4'd2, 4'd2, 1'b0);
            step();
            if (i == 9) check_eq("r039_ready", obs_ready, 1'b0);
            busy_cnt += int'(obs_busy);
            done_cnt += int'(obs_done);
        end
        check_eq("r039_busy_len", busy_cnt, 16);
        check_eq("r039_done_len", done_cnt, 1);
        check_eq("r039_r2", obs_a, 8'h00);

        // Reset in the middle of a clear.
        fill_index_plus_one();
        drive(1'b0, 4'd0, 8'h00, 4'd15, 4'd9, 1'b1);
        step();
        drive(1'b0, 4'd0, 8'h00, 4'd15, 4'd9, 1'b0);
        for (int i = 0; i < 5; i++) step();
        rst_n = 1'b0;
        step();
        check_eq("r040_busy", obs_busy, 1'b0);
        check_eq("r040_rtop", obs_rtop, 8'h00);
        check_eq("r040_b9", obs_b, 8'h00);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            done_cnt += int'(obs_done);
        end
        check_eq("r040_no_done", done_cnt, 0);

        // Writes to R0: stored on default instance, masked on the variant.
        drive(1'b1, 4'd0, 8'hFF, 4'd0, 4'd0, 1'b0);
        step();
        drive(1'b0, 4'd0, 8'h00, 4'd0, 4'd0, 1'b0);
        step();
        check_eq("r040_r0_alt", obs_za, 8'h00);
        check_eq("r040_r0_dflt", obs_a, 8'hFF);

        // Randomised traffic including occasional clears and resets.
        for (int i = 0; i < 1500; i++) begin
            rst_n = ($urandom_range(0, 149) != 0);
            drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 29) == 0));
            if ($urandom_range(0, 3) == 0) a_sel = wr_sel;
            step();
        end
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Guard against an unexpected stall of the stimulus thread.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
